// File: rtl/mips_irq_ctl_pkg.sv
// mips_irq_ctl shared definitions: register map, FSM states, vector defaults.
// Optional feature macro used by this block: IRQ_SYNC_EN.
package mips_irq_ctl_pkg;

  localparam logic [1:0] IRQ_PEND = 2'd0;
  localparam logic [1:0] IRQ_MASK = 2'd1;
  localparam logic [1:0] IRQ_CTRL = 2'd2;
  localparam logic [1:0] IRQ_ACT  = 2'd3;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0050;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } irq_state_t;

  function automatic logic [31:0] irq_vec(
    input logic [31:0] base,
    input logic [31:0] stride,
    input logic [2:0]  id
  );
    return base + 32'(id) * stride;
  endfunction

endpackage

// File: rtl/mips_irq_ctl_if.sv
// Device-bus and core-interrupt signals of the interrupt controller.
// master = bus/core side, slave = controller side.
interface mips_irq_ctl_if;
  logic [1:0]  addr_i;
  logic [31:0] din_i;
  logic        we_i;
  logic [31:0] dout_o;
  logic        irq_req_o;
  logic [31:0] irq_addr_o;
  logic        irq_ack_i;

  modport master (
    output addr_i, din_i, we_i, irq_ack_i,
    input  dout_o, irq_req_o, irq_addr_o
  );

  modport slave (
    input  addr_i, din_i, we_i, irq_ack_i,
    output dout_o, irq_req_o, irq_addr_o
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; id is 3 bits for up to 8 sources.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [2:0]   id
);

  always_comb begin
    found = 1'b0;
    id    = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        found = 1'b1;
        id    = 3'(k);
      end
    end
  end

endmodule

// File: rtl/mips_irq_ctl.sv
// Interrupt controller in front of the MIPS core's single irq input.
// Define IRQ_SYNC_EN to add a 2-flop synchronizer on every src_i bit.
module mips_irq_ctl
  import mips_irq_ctl_pkg::*;
#(
  parameter int          NSRC       = 4,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_i,
  mips_irq_ctl_if.slave   bus
);

  logic [NSRC-1:0] src_s;
  logic [NSRC-1:0] s1, s2, rise;
  logic [NSRC-1:0] pend, pend_nxt;
  logic [NSRC-1:0] mask, mask_nxt;
  logic [NSRC-1:0] w1c, id_oh, ack_clr;
  logic            gen, gen_nxt;
  logic            wr_pend, wr_mask, wr_ctrl, wr_act;
  logic            ack_ev, live;
  logic            found;
  logic [2:0]      win_id;
  logic [2:0]      id;
  logic            act_v;
  logic [31:0]     rdata;
  irq_state_t      state;

  logic unused_din;
  assign unused_din = ^bus.din_i;

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sy0, sy1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sy0 <= '0;
      sy1 <= '0;
    end else begin
      sy0 <= src_i;
      sy1 <= sy0;
    end
  end

  assign src_s = sy1;
`else
  assign src_s = src_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= src_s;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

  assign wr_pend = bus.we_i && (bus.addr_i == IRQ_PEND);
  assign wr_mask = bus.we_i && (bus.addr_i == IRQ_MASK);
  assign wr_ctrl = bus.we_i && (bus.addr_i == IRQ_CTRL);
  assign wr_act  = bus.we_i && (bus.addr_i == IRQ_ACT);
  assign ack_ev  = (state == ST_REQ) && bus.irq_ack_i;

  always_comb begin
    id_oh = '0;
    for (int k = 0; k < NSRC; k++) begin
      id_oh[k] = (id == 3'(k));
    end
  end

  assign w1c     = wr_pend ? bus.din_i[NSRC-1:0] : '0;
  assign ack_clr = ack_ev ? id_oh : '0;

  // A fresh edge beats both W1C and the ack clear of the same bit.
  assign pend_nxt = (pend & ~w1c & ~ack_clr) | rise;
  assign mask_nxt = wr_mask ? bus.din_i[NSRC-1:0] : mask;
  assign gen_nxt  = wr_ctrl ? bus.din_i[0] : gen;
  assign live     = gen_nxt && |(pend_nxt & mask_nxt & id_oh);

  irq_prio_enc #(
    .N (NSRC)
  ) u_prio (
    .req   (pend & mask & {NSRC{gen}}),
    .found (found),
    .id    (win_id)
  );

  always_comb begin
    rdata = '0;
    unique case (bus.addr_i)
      IRQ_PEND: rdata = 32'(pend);
      IRQ_MASK: rdata = 32'(mask);
      IRQ_CTRL: rdata = {31'b0, gen};
      IRQ_ACT:  rdata = act_v ? {1'b1, 27'b0, 1'b0, id} : '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      mask       <= '0;
      gen        <= 1'b0;
      bus.dout_o <= '0;
    end else begin
      pend       <= pend_nxt;
      mask       <= mask_nxt;
      gen        <= gen_nxt;
      bus.dout_o <= rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      id             <= '0;
      act_v          <= 1'b0;
      bus.irq_req_o  <= 1'b0;
      bus.irq_addr_o <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (found) begin
            id             <= win_id;
            bus.irq_addr_o <= irq_vec(VEC_BASE, VEC_STRIDE, win_id);
            bus.irq_req_o  <= 1'b1;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_ev) begin
            bus.irq_req_o <= 1'b0;
            act_v         <= 1'b1;
            state         <= ST_SERVICE;
          end else if (!live) begin
            bus.irq_req_o <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (wr_act) begin
            act_v <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_irq_ctl.sv
// Randomized and directed bench for mips_irq_ctl against a behavioural model.
// Honours IRQ_SYNC_EN for the source-to-request latency.
module tb_mips_irq_ctl;

  localparam int NSRC = 4;
`ifdef IRQ_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif
  localparam int LAT = D + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src;

  mips_irq_ctl_if bif ();

  mips_irq_ctl #(
    .NSRC (NSRC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .src_i (src),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [NSRC-1:0] m_pend, m_mask;
  logic [NSRC-1:0] s_hist [4];
  bit              m_gen, m_req, m_actv;
  int              m_st;
  int              m_id;
  logic [31:0]     m_addr, m_dout;

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_gen = 0;
    m_req = 0; m_actv = 0; m_st = 0; m_id = 0;
    m_addr = '0; m_dout = '0;
    for (int j = 0; j < 4; j++) s_hist[j] = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_mask);
      2'd2:    return {31'b0, m_gen};
      default: return m_actv ? (32'h8000_0000 | 32'(m_id)) : 32'h0;
    endcase
  endfunction

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    logic [NSRC-1:0] rise, w1c, np, nm;
    bit ng, ack_ev, eoi, found;
    rise   = s_hist[D-1] & ~s_hist[D];
    w1c    = (bif.we_i && bif.addr_i == 2'd0) ? bif.din_i[NSRC-1:0] : '0;
    ack_ev = (m_st == 1) && bif.irq_ack_i;
    eoi    = bif.we_i && bif.addr_i == 2'd3;
    np = m_pend & ~w1c;
    if (ack_ev) np[m_id] = 1'b0;
    np = np | rise;
    nm = (bif.we_i && bif.addr_i == 2'd1) ? bif.din_i[NSRC-1:0] : m_mask;
    ng = (bif.we_i && bif.addr_i == 2'd2) ? bif.din_i[0] : m_gen;
    m_dout = m_read(bif.addr_i);
    if (m_st == 0) begin
      found = 0;
      for (int k = 0; k < NSRC; k++) begin
        if (!found && m_gen && m_pend[k] && m_mask[k]) begin
          found = 1;
          m_id = k;
          m_addr = 32'h50 + 32'(8 * k);
          m_req = 1;
          m_st = 1;
        end
      end
    end else if (m_st == 1) begin
      if (ack_ev) begin
        m_req = 0; m_actv = 1; m_st = 2;
      end else if (!(np[m_id] && nm[m_id] && ng)) begin
        m_req = 0; m_st = 0;
      end
    end else if (eoi) begin
      m_actv = 0; m_st = 0;
    end
    m_pend = np; m_mask = nm; m_gen = ng;
    for (int j = 3; j > 0; j--) s_hist[j] = s_hist[j-1];
    s_hist[0] = src;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    chk("req", {31'b0, bif.irq_req_o}, {31'b0, m_req});
    chk("vec", bif.irq_addr_o, m_addr);
    chk("dout", bif.dout_o, m_dout);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bif.addr_i = a; bif.din_i = d; bif.we_i = 1'b1;
    tick();
    bif.we_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a,
                        input logic [31:0] exp);
    bif.addr_i = a;
    tick();
    tick();
    chk(tag, bif.dout_o, exp);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bif.irq_req_o && n < 12) begin
      tick();
      n++;
    end
    if (!bif.irq_req_o) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic ack();
    bif.irq_ack_i = 1'b1;
    tick();
    bif.irq_ack_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1; src = '0;
    bif.addr_i = '0; bif.din_i = '0; bif.we_i = 1'b0; bif.irq_ack_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_req", {31'b0, bif.irq_req_o}, 32'd0);
    chk("rst_vec", bif.irq_addr_o, 32'd0);
    for (int a = 0; a < 4; a++) rd_chk("rst_reg", 2'(a), 32'd0);

    // Single source, latency and vector
    wr(2'd1, 32'hF);
    wr(2'd2, 32'h1);
    src = 4'b0100;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk("latency", {31'b0, bif.irq_req_o}, (i == LAT) ? 32'd1 : 32'd0);
    end
    src = '0;
    chk("vec_src2", bif.irq_addr_o, 32'h60);
    ack();
    rd_chk("pend_after_ack", 2'd0, 32'd0);
    rd_chk("act_src2", 2'd3, 32'h8000_0002);
    wr(2'd3, 32'd0);
    rd_chk("act_after_eoi", 2'd3, 32'd0);

    // Two sources at once: priority, then the second after EOI
    src = 4'b1010;
    wait_req("prio1");
    src = '0;
    chk("vec_prio_first", bif.irq_addr_o, 32'h58);
    ack();
    rd_chk("svc_no_nest", 2'd0, 32'h8);
    chk("svc_no_req", {31'b0, bif.irq_req_o}, 32'd0);
    wr(2'd3, 32'd0);
    wait_req("prio2");
    chk("vec_prio_second", bif.irq_addr_o, 32'h68);
    ack();
    wr(2'd3, 32'd0);

    // Withdraw by mask clear, then reissue
    src = 4'b0010;
    tick();
    src = '0;
    wait_req("wd");
    wr(2'd1, 32'd0);
    chk("withdraw_req", {31'b0, bif.irq_req_o}, 32'd0);
    rd_chk("withdraw_pend", 2'd0, 32'h2);
    wr(2'd1, 32'hF);
    wait_req("reissue");
    chk("reissue_vec", bif.irq_addr_o, 32'h58);
    ack();
    wr(2'd3, 32'd0);

    // Edge capture beats W1C in the same cycle
    wr(2'd2, 32'd0);
    src = 4'b0001;
    repeat (D) tick();
    wr(2'd0, 32'h1);
    rd_chk("set_beats_w1c", 2'd0, 32'h1);
    wr(2'd2, 32'h1);
    wait_req("held");
    chk("held_vec", bif.irq_addr_o, 32'h50);
    ack();
    wr(2'd3, 32'd0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bif.irq_req_o) cnt++;
    end
    chk("held_one_req", 32'(cnt), 32'd0);
    src = '0;

    // Asynchronous reset while requesting
    src = 4'b1000;
    tick();
    src = '0;
    wait_req("arst");
    #2 rst = 1'b1;
    model_reset();
    #1 chk("async_drop", {31'b0, bif.irq_req_o}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) rd_chk("post_rst_reg", 2'(a), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NSRC; k++) begin
        if ($urandom_range(0, 7) == 0) src[k] = ~src[k];
      end
      bif.addr_i = 2'($urandom_range(0, 3));
      bif.we_i = ($urandom_range(0, 4) == 0);
      bif.din_i = $urandom;
      if (bif.addr_i == 2'd2) bif.din_i[0] = ($urandom_range(0, 4) != 0);
      if (bif.addr_i == 2'd0) bif.din_i[NSRC-1:0] &= 4'($urandom);
      bif.irq_ack_i = m_req ? ($urandom_range(0, 2) == 0)
                            : ($urandom_range(0, 19) == 0);
      tick();
    end
    bif.we_i = 1'b0;
    bif.irq_ack_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
